// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - issue-stage FIFO with long-latency busy scoreboard and hazard hold
//
// Purpose: buffers decoded instructions, holds the FIFO head while it reads or
// writes a register with a long-latency write (load/mul/div) still in flight,
// and hands the head to execute under a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   dec_*                     decoder side: valid/ready, payload, operand and
//                             destination controls, is_long marker
//   iss_*                     execute side: valid/ready, head payload and controls
//   wb_valid, wb_addr         long-latency writeback clears the busy bit
//   flush                     empties the FIFO and the scoreboard next cycle
//   busy_vec                  scoreboard state (bit 0 always 0)
//   stall_cnt                 saturating count of hazard-stall cycles
module issue_ctrl #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 75,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 dec_reg1_read_en,
  input  logic [4:0]           dec_reg1_read_addr,
  input  logic                 dec_reg2_read_en,
  input  logic [4:0]           dec_reg2_read_addr,
  input  logic                 dec_reg_write_en,
  input  logic [4:0]           dec_reg_write_addr,
  input  logic                 dec_is_long,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic                 iss_reg1_read_en,
  output logic                 iss_reg2_read_en,
  output logic                 iss_reg_write_en,
  output logic [4:0]           iss_reg1_read_addr,
  output logic [4:0]           iss_reg2_read_addr,
  output logic [4:0]           iss_reg_write_addr,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic                 flush,
  output logic [31:0]          busy_vec,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int CTL_W = 19;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Control bits of one entry: {r1en, r1a, r2en, r2a, wen, wa, is_long}
  logic [PAYLOAD_W-1:0] r_pay_mem [DEPTH];
  logic [CTL_W-1:0]     r_ctl_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_stall;

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_deq;
  logic             w_hazard;
  logic [CTL_W-1:0] w_head_ctl;
  logic             w_h_r1en;
  logic [4:0]       w_h_r1a;
  logic             w_h_r2en;
  logic [4:0]       w_h_r2a;
  logic             w_h_wen;
  logic [4:0]       w_h_wa;
  logic             w_h_long;
  logic [31:0]      w_busy_nxt;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  assign w_head_ctl = r_ctl_mem[r_rd_ptr];
  assign {w_h_r1en, w_h_r1a, w_h_r2en, w_h_r2a, w_h_wen, w_h_wa, w_h_long} = w_head_ctl;

  // Busy bit 0 is held at 0, so r0 never raises a hazard here.
  assign w_hazard = (w_h_r1en && r_busy[w_h_r1a]) ||
                    (w_h_r2en && r_busy[w_h_r2a]) ||
                    (w_h_wen  && r_busy[w_h_wa]);

  assign dec_ready = !w_full;
  assign iss_valid = !w_empty && !w_hazard && !flush;

  // Flush discards both sides of the handshake in its cycle.
  assign w_enq = dec_valid && !w_full && !flush;
  assign w_deq = iss_valid && iss_ready;

  assign iss_payload        = r_pay_mem[r_rd_ptr];
  assign iss_reg1_read_en   = w_h_r1en;
  assign iss_reg1_read_addr = w_h_r1a;
  assign iss_reg2_read_en   = w_h_r2en;
  assign iss_reg2_read_addr = w_h_r2a;
  assign iss_reg_write_en   = w_h_wen;
  assign iss_reg_write_addr = w_h_wa;

  assign busy_vec  = r_busy;
  assign stall_cnt = r_stall;

  // Clear first, then set: a new producer issued in the same cycle as the old
  // producer's writeback keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_deq && w_h_wen && w_h_long) begin
      w_busy_nxt[w_h_wa] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pay_mem[r_wr_ptr] <= dec_payload;
      r_ctl_mem[r_wr_ptr] <= {dec_reg1_read_en, dec_reg1_read_addr,
                              dec_reg2_read_en, dec_reg2_read_addr,
                              dec_reg_write_en, dec_reg_write_addr,
                              dec_is_long};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      r_stall  <= '0;
    end else begin
      if (!w_empty && w_hazard && !flush && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + CNT_W'(1);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_busy   <= '0;
      end else begin
        r_busy <= w_busy_nxt;
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;

  localparam int PW = 75;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [PW-1:0] dec_payload;
  logic          dec_reg1_read_en;
  logic [4:0]    dec_reg1_read_addr;
  logic          dec_reg2_read_en;
  logic [4:0]    dec_reg2_read_addr;
  logic          dec_reg_write_en;
  logic [4:0]    dec_reg_write_addr;
  logic          dec_is_long;
  logic          iss_valid;
  logic          iss_ready;
  logic [PW-1:0] iss_payload;
  logic          iss_reg1_read_en;
  logic          iss_reg2_read_en;
  logic          iss_reg_write_en;
  logic [4:0]    iss_reg1_read_addr;
  logic [4:0]    iss_reg2_read_addr;
  logic [4:0]    iss_reg_write_addr;
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic          flush;
  logic [31:0]   busy_vec;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.DEPTH(2), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_payload(dec_payload),
    .dec_reg1_read_en(dec_reg1_read_en), .dec_reg1_read_addr(dec_reg1_read_addr),
    .dec_reg2_read_en(dec_reg2_read_en), .dec_reg2_read_addr(dec_reg2_read_addr),
    .dec_reg_write_en(dec_reg_write_en), .dec_reg_write_addr(dec_reg_write_addr),
    .dec_is_long(dec_is_long),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .iss_reg1_read_en(iss_reg1_read_en), .iss_reg2_read_en(iss_reg2_read_en),
    .iss_reg_write_en(iss_reg_write_en),
    .iss_reg1_read_addr(iss_reg1_read_addr), .iss_reg2_read_addr(iss_reg2_read_addr),
    .iss_reg_write_addr(iss_reg_write_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  function automatic logic [PW-1:0] mk_pay(input logic [31:0] pc);
    return {pc, pc ^ 32'h5a5a_0000, 3'd2, pc[7:0]};
  endfunction

  // Inputs change on the falling edge; checks follow #1 later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic r1en, input logic [4:0] r1a,
                       input logic r2en, input logic [4:0] r2a,
                       input logic wen, input logic [4:0] wa, input logic lng);
    dec_valid          = v;
    dec_payload        = mk_pay(pc);
    dec_reg1_read_en   = r1en;
    dec_reg1_read_addr = r1a;
    dec_reg2_read_en   = r2en;
    dec_reg2_read_addr = r2a;
    dec_reg_write_en   = wen;
    dec_reg_write_addr = wa;
    dec_is_long        = lng;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0; iss_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_basic();
    tick();
    iss_ready = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_no_fallthrough got=%b exp=0", iss_valid); end
    tick();
    dec_valid = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_iss_valid got=%b exp=1", iss_valid); end
    total++; if (iss_payload !== mk_pay(32'h100)) begin bad++; $display("FAIL basic_payload got=%h exp=%h", iss_payload, mk_pay(32'h100)); end
    total++; if (iss_reg_write_addr !== 5'd4 || iss_reg1_read_addr !== 5'd5) begin bad++; $display("FAIL basic_addrs got=%0d/%0d exp=4/5", iss_reg_write_addr, iss_reg1_read_addr); end
    tick();
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", iss_valid); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL basic_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_raw();
    iss_ready = 1'b1;
    drive(1'b1, 32'h200, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1);
    tick();
    dec_valid = 1'b0;
    tick();
    #1;
    total++; if (busy_vec !== 32'h40) begin bad++; $display("FAIL raw_busy_set got=%h exp=40", busy_vec); end
    drive(1'b1, 32'h204, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    tick();
    dec_valid = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL raw_hold got=%b exp=0", iss_valid); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL raw_stall0 got=%0d exp=0", stall_cnt); end
    tick(); tick(); tick();
    #1;
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_stall3 got=%0d exp=3", stall_cnt); end
    wb_valid = 1'b1; wb_addr = 5'd6;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL raw_no_bypass got=%b exp=0", iss_valid); end
    tick();
    wb_valid = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", iss_valid); end
    total++; if (iss_payload !== mk_pay(32'h204)) begin bad++; $display("FAIL raw_payload got=%h exp=%h", iss_payload, mk_pay(32'h204)); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL raw_stall4 got=%0d exp=4", stall_cnt); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL raw_busy_clr got=%h exp=0", busy_vec); end
    tick();
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL raw_drained got=%b exp=0", iss_valid); end
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    drive(1'b1, 32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL full_one_ready got=%b exp=1", dec_ready); end
    tick();
    drive(1'b1, 32'h308, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready got=%b exp=0", dec_ready); end
    total++; if (iss_payload !== mk_pay(32'h300)) begin bad++; $display("FAIL full_head got=%h exp=%h", iss_payload, mk_pay(32'h300)); end
    tick();
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL full_held got=%b exp=0", dec_ready); end
    dec_valid = 1'b0;
    iss_ready = 1'b1;
    #1;
    total++; if (iss_valid !== 1'b1 || iss_payload !== mk_pay(32'h300)) begin bad++; $display("FAIL full_first got=%b/%h exp=1/%h", iss_valid, iss_payload, mk_pay(32'h300)); end
    tick();
    #1;
    total++; if (iss_valid !== 1'b1 || iss_payload !== mk_pay(32'h304)) begin bad++; $display("FAIL full_second got=%b/%h exp=1/%h", iss_valid, iss_payload, mk_pay(32'h304)); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b exp=1", dec_ready); end
    tick();
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_third_dropped got=%b exp=0", iss_valid); end
  endtask

  task automatic test_collision();
    iss_ready = 1'b1;
    drive(1'b1, 32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
    tick();
    dec_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd9;
    #1;
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL coll_head got=%b exp=1", iss_valid); end
    tick();
    wb_valid = 1'b0;
    #1;
    total++; if (busy_vec !== 32'h200) begin bad++; $display("FAIL coll_set_wins got=%h exp=200", busy_vec); end
    wb_valid = 1'b1; wb_addr = 5'd9;
    tick();
    wb_valid = 1'b0;
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL coll_clear got=%h exp=0", busy_vec); end
  endtask

  task automatic test_r0();
    iss_ready = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    drive(1'b1, 32'h504, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    dec_valid = 1'b0;
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL r0_busy got=%h exp=0", busy_vec); end
    total++; if (iss_valid !== 1'b1 || iss_payload !== mk_pay(32'h504)) begin bad++; $display("FAIL r0_read_issues got=%b/%h exp=1/%h", iss_valid, iss_payload, mk_pay(32'h504)); end
    tick();
    #1;
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL r0_no_stall got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_flush();
    iss_ready = 1'b1;
    drive(1'b1, 32'h600, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
    tick();
    drive(1'b1, 32'h604, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
    tick();
    dec_valid = 1'b0;
    tick();
    #1;
    total++; if (busy_vec !== 32'h300) begin bad++; $display("FAIL flush_setup_busy got=%h exp=300", busy_vec); end
    iss_ready = 1'b0;
    drive(1'b1, 32'h608, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 32'h60c, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    #1;
    total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL flush_setup_full got=%b exp=0", dec_ready); end
    drive(1'b1, 32'h610, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    iss_ready = 1'b1;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_gates_issue got=%b exp=0", iss_valid); end
    tick();
    flush = 1'b0;
    dec_valid = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", iss_valid); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL flush_busy got=%h exp=0", busy_vec); end
    total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", dec_ready); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_stall got=%0d exp=4", stall_cnt); end
    tick();
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_enq_dropped got=%b exp=0", iss_valid); end
  endtask

  task automatic test_mid_reset();
    iss_ready = 1'b1;
    drive(1'b1, 32'h700, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
    tick();
    dec_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd3;
    #1;
    total++; if (busy_vec !== 32'h0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL midreset got=%h/%0d exp=0/0", busy_vec, stall_cnt); end
    tick();
    wb_valid = 1'b0;
    #1;
    total++; if (busy_vec !== 32'h0 || iss_valid !== 1'b0) begin bad++; $display("FAIL midreset_wb got=%h/%b exp=0/0", busy_vec, iss_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_full();
    test_collision();
    test_r0();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue-stage scheduler between the 2RI12/3R decoders and the execute unit.
- Buffers decoded instructions in a small FIFO and tracks pending long-latency register writes (load/mul/div) in a 32-entry busy scoreboard.
- Holds the FIFO head while it has a RAW or WAW hazard against the scoreboard, and releases instructions to execute under a valid/ready handshake.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- PAYLOAD_W, 75, opaque payload bits {pc[31:0], imm[31:0], alusel[2:0], aluop[7:0]}.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- dec_valid  in  1  decoder offers an instruction.
- dec_ready  out  1  FIFO can accept.
- dec_payload  in  PAYLOAD_W  opaque decoded fields.
- dec_reg1_read_en  in  1  source operand 1 is read.
- dec_reg1_read_addr  in  5  source operand 1 address.
- dec_reg2_read_en  in  1  source operand 2 is read.
- dec_reg2_read_addr  in  5  source operand 2 address.
- dec_reg_write_en  in  1  instruction writes a register.
- dec_reg_write_addr  in  5  destination register.
- dec_is_long  in  1  result returns through writeback later (load/mul/div).
- iss_valid  out  1  head is issuable.
- iss_ready  in  1  execute accepts.
- iss_payload  out  PAYLOAD_W  head payload.
- iss_reg1_read_en, iss_reg2_read_en, iss_reg_write_en  out  1 each  head control bits.
- iss_reg1_read_addr, iss_reg2_read_addr, iss_reg_write_addr  out  5 each  head addresses.
- wb_valid  in  1  long-latency result written back.
- wb_addr  in  5  register written back.
- flush  in  1  pipeline flush (branch mispredict / exception).
- busy_vec  out  32  scoreboard state (debug).
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating.

Behaviour:
- Reset (rst==0 at posedge): FIFO empty; busy_vec=0; stall_cnt=0.
  - Outputs after reset: dec_ready=1, iss_valid=0; iss_* fields are don't-care while iss_valid=0.
- FIFO behaviour:
  - Enqueue when dec_valid && dec_ready.
  - dec_ready = !full, registered-count based. No combinational dependence on iss_ready.
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue+dequeue while full: not allowed, because dec_ready=0 when full.
  - Simultaneous enqueue+dequeue while non-full: count unchanged.
  - Empty FIFO: no fall-through; minimum latency from enqueue to iss_valid is 1 cycle.
- Hazard (combinational on head and registered busy_vec):
  - hazard = (r1en && busy[r1a]) || (r2en && busy[r2a]) || (wen && busy[wa]).
  - Register 0 never counts as busy; busy_vec[0] is tied to 0.
- Issue:
  - iss_valid = !empty && !hazard && !flush.
  - Dequeue on iss_valid && iss_ready.
  - iss_* fields present the head entry.
- Scoreboard:
  - Set: on dequeue with wen && is_long && wa!=0, busy[wa]←1.
  - Clear: on wb_valid, busy[wb_addr]←0.
  - Same register set and cleared in one cycle: set wins (the new producer supersedes).
  - A writeback does not unblock the head until the following cycle (no same-cycle bypass).
- Stall counter:
  - Increments when !empty && hazard && !flush.
  - Saturates at all-ones.
  - Cleared only by reset.
- Flush, registered:
  - Next cycle: FIFO empty, busy_vec=0.
  - Enqueue and dequeue in the flush cycle are discarded.
  - Flush has priority over wb_valid and dec_valid.
- Reset mid-operation: identical to power-on reset; in-flight writebacks after reset only clear already-zero bits.

Test Plan:
- Basic flow: reset, push ADDI r4←r5 (is_long=0), iss_ready=1 → iss_valid=1 one cycle later, payload matches, busy_vec stays 0.
- RAW stall: issue load r6 (is_long=1) → busy_vec=0x40.
  - Then push ORI r7←r6 → iss_valid=0 and stall_cnt counts each cycle.
  - wb_valid with wb_addr=6 at cycle N → iss_valid=1 at N+1.
- Full/backpressure: iss_ready=0, push 2 instructions → dec_ready=0. Third dec_valid is held, not enqueued. iss_ready=1 → order preserved, dec_ready returns to 1.
- Set/clear collision: head is load r9 dequeuing while wb_valid with wb_addr=9 in the same cycle → busy_vec[9]=1 next cycle.
- r0 handling: load with write address 0 and is_long=1 → busy_vec remains 0; following read of r0 issues without stall.
- Flush: FIFO holds 2 entries and busy_vec=0x300, assert flush with dec_valid=1 → next cycle empty, busy_vec=0, iss_valid=0, stall_cnt unchanged.
